mips_dmem_responder: RTL and testbench

//  Responder side of the MIPS datapath data-memory port: accepts load/store requests
//  (address = ALU result, store data = rt value) and returns load data.

---
 rtl/mips_dmem_responder_if.sv | 22 ++
 rtl/mips_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_mips_dmem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_responder_if.sv
// Datapath-to-data-memory port: load/store request with address and store data, load data and stall back.
// The datapath holds its request steady while stall is high.
interface mips_dmem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  memread;
  logic                  memwrite;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  stall;

  modport master (
    output memread, memwrite, addr, writedata,
    input  readdata, stall
  );

  modport slave (
    input  memread, memwrite, addr, writedata,
    output readdata, stall
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Wait-stated data RAM plus one memory-mapped output register; an access stalls WAIT_STATES+1 cycles, then retires in one DONE cycle.
// Backpressure: stall holds the datapath; with WAIT_STATES=0 there is no stall and reads are combinational.
module mips_dmem_responder #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 256,
  parameter int                    WAIT_STATES = 2,
  parameter logic [DATA_WIDTH-1:0] MMIO_ADDR   = 32'hFFFF_FFFC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mips_dmem_responder_if.slave  io_mem,
  output logic [DATA_WIDTH-1:0] o_mmio_out,
  output logic                  o_misalign_err
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_readdata;
  logic [DATA_WIDTH-1:0] r_mmio;
  logic                  r_err;

  // Request copy taken in IDLE; the held inputs are not looked at again until DONE.
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_mmio;
  logic                  r_rd;
  logic                  r_wr;

  logic                  w_req;
  logic                  w_aligned;
  logic                  w_is_mmio;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_misalign;
  logic                  w_latch;
  logic                  w_stall;
  logic                  w_busy_commit;
  logic                  w_commit;

  logic                  w_c_rd;
  logic                  w_c_wr;
  logic                  w_c_mmio;
  logic [IDX_W-1:0]      w_c_idx;
  logic [DATA_WIDTH-1:0] w_c_wdata;
  logic [DATA_WIDTH-1:0] w_rdata_src;

  assign w_req      = io_mem.memread | io_mem.memwrite;
  assign w_aligned  = (io_mem.addr[1:0] == 2'b00);
  assign w_is_mmio  = (io_mem.addr == MMIO_ADDR);
  assign w_idx      = io_mem.addr[IDX_W+1:2];
  assign w_misalign = (r_state == S_IDLE) & w_req & ~w_aligned;

  // Zero-wait RAM commits straight from the live request; otherwise from the latched copy.
  assign w_c_rd    = ZERO_WAIT ? io_mem.memread   : r_rd;
  assign w_c_wr    = ZERO_WAIT ? io_mem.memwrite  : r_wr;
  assign w_c_mmio  = ZERO_WAIT ? w_is_mmio        : r_is_mmio;
  assign w_c_idx   = ZERO_WAIT ? w_idx            : r_idx;
  assign w_c_wdata = ZERO_WAIT ? io_mem.writedata : r_wdata;
  assign w_commit  = ZERO_WAIT ? (w_req & w_aligned) : w_busy_commit;

  assign w_rdata_src = w_c_mmio ? r_mmio : r_mem[w_c_idx];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stall       = 1'b0;
    w_latch       = 1'b0;
    w_busy_commit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ZERO_WAIT && w_req && w_aligned) begin
          w_latch     = 1'b1;
          w_stall     = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_busy_commit = 1'b1;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_readdata <= '0;
      r_mmio     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= r_err | w_misalign;
      if (w_commit && w_c_wr && w_c_mmio) begin
        r_mmio <= w_c_wdata;
      end
      // A combined load+store is a store that returns zero.
      if (!ZERO_WAIT && w_commit && w_c_rd) begin
        r_readdata <= w_c_wr ? '0 : w_rdata_src;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_latch) begin
      r_idx     <= w_idx;
      r_wdata   <= io_mem.writedata;
      r_is_mmio <= w_is_mmio;
      r_rd      <= io_mem.memread;
      r_wr      <= io_mem.memwrite;
    end
  end

  // Reset blocks the write so an access interrupted at its commit cycle leaves RAM untouched.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit && w_c_wr && !w_c_mmio) begin
      r_mem[w_c_idx] <= w_c_wdata;
    end
  end

  always_comb begin
    if (ZERO_WAIT) begin
      io_mem.readdata = (w_misalign || (io_mem.memread && io_mem.memwrite)) ? '0 : w_rdata_src;
    end else begin
      io_mem.readdata = w_misalign ? '0 : r_readdata;
    end
  end

  assign io_mem.stall    = w_stall;
  assign o_mmio_out      = r_mmio;
  assign o_misalign_err  = r_err;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: a 2-wait-state instance driven from a vector table plus reset/hold
// sequences, and a zero-wait instance exercised by hand.
module tb_mips_dmem_responder;

  localparam logic [31:0] MMIO = 32'hFFFF_FFFC;
  localparam int          NV   = 12;

  logic        clk = 1'b0;
  logic        rst2;
  logic        rst0;
  logic [31:0] mmio2;
  logic [31:0] mmio0;
  logic        err2;
  logic        err0;
  int          n_pass  = 0;
  int          n_total = 0;
  bit          mon0_en = 1'b0;
  bit          saw_stall0 = 1'b0;

  always #5 clk = ~clk;

  mips_dmem_responder_if #(.DATA_WIDTH(32)) bus2 ();
  mips_dmem_responder_if #(.DATA_WIDTH(32)) bus0 ();

  mips_dmem_responder #(
    .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(2), .MMIO_ADDR(MMIO)
  ) dut2 (
    .i_clk(clk), .i_rst(rst2), .io_mem(bus2), .o_mmio_out(mmio2), .o_misalign_err(err2)
  );

  mips_dmem_responder #(
    .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0), .MMIO_ADDR(MMIO)
  ) dut0 (
    .i_clk(clk), .i_rst(rst0), .io_mem(bus0), .o_mmio_out(mmio0), .o_misalign_err(err0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mmio;
    logic        exp_err;
  } vec_t;

  vec_t vecs [NV];

  always @(negedge clk) begin
    if (mon0_en && bus0.stall !== 1'b0) saw_stall0 = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Entered #1 after a posedge; returns #1 after the posedge that ends the retiring cycle.
  task automatic access2(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    bus2.memread   = rd;
    bus2.memwrite  = wr;
    bus2.addr      = addr;
    bus2.writedata = wdata;
    stalls = 0;
    @(negedge clk);
    while (bus2.stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    rdata = bus2.readdata;
    @(posedge clk);
    #1;
    bus2.memread  = 1'b0;
    bus2.memwrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          stalls;
    logic [31:0] rdata;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0000_0000, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1111_1111, 3, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, MMIO,          32'h0000_005A, 3, 32'hDEAD_BEEF, 32'h5A, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         3, 32'h1111_1111, 32'h5A, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, MMIO,          32'h0,         3, 32'h0000_005A, 32'h5A, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0014, 32'h0000_0077, 3, 32'h0000_0000, 32'h5A, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,         3, 32'h0000_0077, 32'h5A, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_600D, 3, 32'h0000_0077, 32'h5A, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         0, 32'h0000_0000, 32'h5A, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0410, 32'h0,         3, 32'hDEAD_BEEF, 32'h5A, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         3, 32'h0000_600D, 32'h5A, 1'b1};

    bus2.memread = 1'b0; bus2.memwrite = 1'b0; bus2.addr = '0; bus2.writedata = '0;
    bus0.memread = 1'b0; bus0.memwrite = 1'b0; bus0.addr = '0; bus0.writedata = '0;
    rst2 = 1'b1;
    rst0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    rst0 = 1'b0;
    mon0_en = 1'b1;

    @(negedge clk);
    check("rst2_readdata", bus2.readdata, 32'h0);
    check("rst2_mmio", mmio2, 32'h0);
    check("rst2_stall", {31'b0, bus2.stall}, 32'h0);
    check("rst2_err", {31'b0, err2}, 32'h0);
    check("rst0_mmio", mmio0, 32'h0);
    check("rst0_stall", {31'b0, bus0.stall}, 32'h0);
    check("rst0_err", {31'b0, err0}, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      access2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, rdata);
      check($sformatf("v%0d_stall_cycles", i), stalls, vecs[i].exp_stall);
      check($sformatf("v%0d_readdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mmio", i), mmio2, vecs[i].exp_mmio);
      check($sformatf("v%0d_misalign_err", i), {31'b0, err2}, {31'b0, vecs[i].exp_err});
    end

    // Reset pulse on the commit cycle of a store must drop the store.
    bus2.memwrite = 1'b1; bus2.addr = 32'h20; bus2.writedata = 32'h0000_0BAD;
    @(negedge clk);
    check("abort_stall_idle", {31'b0, bus2.stall}, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_stall_busy", {31'b0, bus2.stall}, 32'h1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus2.memwrite = 1'b0;
    @(negedge clk);
    check("abort_stall_after_rst", {31'b0, bus2.stall}, 32'h0);
    check("abort_err_cleared", {31'b0, err2}, 32'h0);
    check("abort_mmio_cleared", mmio2, 32'h0);
    check("abort_readdata_cleared", bus2.readdata, 32'h0);
    @(posedge clk); #1;
    access2(1'b1, 1'b0, 32'h20, 32'h0, stalls, rdata);
    check("abort_reload_stall", stalls, 32'd3);
    check("abort_reload_data", rdata, 32'h0000_600D);

    // Inputs wobbling during BUSY must not affect the latched store.
    bus2.memwrite = 1'b1; bus2.addr = 32'h24; bus2.writedata = 32'h0000_0123;
    @(posedge clk); #1;
    bus2.addr = 32'h28; bus2.writedata = 32'hFFFF_FFFF; bus2.memread = 1'b1;
    stalls = 1;
    @(negedge clk);
    while (bus2.stall === 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    check("hold_stall_cycles", stalls, 32'd3);
    @(posedge clk); #1;
    bus2.memread = 1'b0; bus2.memwrite = 1'b0;
    access2(1'b1, 1'b0, 32'h24, 32'h0, stalls, rdata);
    check("hold_store_data", rdata, 32'h0000_0123);

    // Zero-wait instance.
    bus0.memwrite = 1'b1; bus0.addr = 32'h404; bus0.writedata = 32'h0000_1234;
    @(negedge clk);
    check("ws0_store_stall", {31'b0, bus0.stall}, 32'h0);
    @(posedge clk); #1;
    bus0.memwrite = 1'b0; bus0.memread = 1'b1; bus0.addr = 32'h004;
    #1;
    check("ws0_alias_load", bus0.readdata, 32'h0000_1234);
    bus0.memread = 1'b0; bus0.memwrite = 1'b1; bus0.addr = MMIO; bus0.writedata = 32'h0000_00AB;
    @(posedge clk); #1;
    check("ws0_mmio_out", mmio0, 32'h0000_00AB);
    bus0.memwrite = 1'b0; bus0.memread = 1'b1;
    #1;
    check("ws0_mmio_load", bus0.readdata, 32'h0000_00AB);
    bus0.addr = 32'h006;
    #1;
    check("ws0_misalign_readdata", bus0.readdata, 32'h0);
    check("ws0_err_before_edge", {31'b0, err0}, 32'h0);
    @(posedge clk); #1;
    check("ws0_err_after_edge", {31'b0, err0}, 32'h1);
    bus0.memread = 1'b0;
    @(posedge clk); #1;
    check("ws0_stall_never", {31'b0, saw_stall0}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
